// File: rtl/sum_pipe_arb.sv
// rtl/sum_pipe_arb.sv - round-robin sequencer sharing one pipelined adder between two requesters
// Tags ride alongside the external adder so each sum returns with its requester ID.
module sum_pipe_arb #(
  parameter int W     = 4,
  parameter int LAT   = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_A,
  input  logic [W-1:0]     req0_B,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_A,
  input  logic [W-1:0]     req1_B,
  output logic             req1_ready,
  output logic [W-1:0]     add_A,
  output logic [W-1:0]     add_B,
  input  logic [W-1:0]     add_sum,
  output logic             res_valid,
  output logic             res_id,
  output logic [W-1:0]     res_sum,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last;
  logic [LAT-1:0]   r_tag_v;
  logic [LAT-1:0]   r_tag_id;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_run;
  logic w_gnt0;
  logic w_gnt1;
  logic w_grant;
  logic w_tags_busy;

  assign w_run       = (r_state == S_RUN) && !reset;
  // r_last resets to 1 so the first contention falls to requester 0
  assign w_gnt0      = w_run && req0_valid && (!req1_valid || r_last);
  assign w_gnt1      = w_run && req1_valid && (!req0_valid || !r_last);
  assign w_grant     = w_gnt0 || w_gnt1;
  assign w_tags_busy = |r_tag_v;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)                w_state_nxt = S_RUN;
        else if (!w_tags_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_tag_v  <= '0;
      r_tag_id <= '0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_last <= w_gnt1;
      r_tag_v[0]  <= w_grant;
      r_tag_id[0] <= w_gnt1;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      if (w_gnt0 && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_gnt1 && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign add_A      = w_gnt0 ? req0_A : (w_gnt1 ? req1_A : '0);
  assign add_B      = w_gnt0 ? req0_B : (w_gnt1 ? req1_B : '0);

  // Stale operands left in the adder after reset are masked because their tags are gone
  assign res_valid  = r_tag_v[LAT-1] && !reset;
  assign res_id     = r_tag_id[LAT-1] && !reset;
  assign res_sum    = res_valid ? add_sum : '0;
  assign busy       = !reset && ((r_state != S_IDLE) || w_tags_busy);
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_sum_pipe_arb.sv
// tb/tb_sum_pipe_arb.sv - scoreboard bench for sum_pipe_arb with a 3-stage adder model
module tb_sum_pipe_arb;

  logic       clk = 1'b0;
  logic       reset, en;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0] add_A, add_B, add_sum, res_sum;
  logic       res_valid, res_id, busy;
  logic [1:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        id;
    logic [3:0]  sum;
    logic [31:0] at;
  } exp_t;
  exp_t q[$];

  logic [3:0] r_p [3] = '{default: '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    r_p[0] <= add_A + add_B;
    r_p[1] <= r_p[0];
    r_p[2] <= r_p[1];
  end
  assign add_sum = r_p[2];

  sum_pipe_arb #(.W(4), .LAT(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req0_valid(req0_valid), .req0_A(req0_A), .req0_B(req0_B), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_A(req1_A), .req1_B(req1_B), .req1_ready(req1_ready),
    .add_A(add_A), .add_B(add_B), .add_sum(add_sum),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                      input logic e0, input logic e1, input logic [3:0] esum);
    req0_valid = v0; req0_A = a0; req0_B = b0;
    req1_valid = v1; req1_A = a1; req1_B = b1;
    @(negedge clk);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    chk("add_A", {28'd0, add_A}, e0 ? {28'd0, a0} : (e1 ? {28'd0, a1} : 32'd0));
    if (e0 || e1) q.push_back(exp_t'{e1, esum, 32'(cyc + 3)});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_A = 4'd5; req0_B = 4'd6;
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_id", {31'd0, res_id}, 0);
    chk("rst_res_sum", {28'd0, res_sum}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_add_A", {28'd0, add_A}, 0);
    chk("rst_add_B", {28'd0, add_B}, 0);
    chk("rst_cnt0", {30'd0, cnt0}, 0);
    chk("rst_cnt1", {30'd0, cnt1}, 0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;

    fork
      forever begin
        @(negedge clk);
        if (res_valid) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got id=%0d sum=%0d at cycle %0d, expected no result", res_id, res_sum, cyc);
          end else begin
            e = q.pop_front();
            chk("res_id", {31'd0, res_id}, {31'd0, e.id});
            chk("res_sum", {28'd0, res_sum}, {28'd0, e.sum});
            chk("res_cycle", cyc, e.at);
          end
        end else if (!reset) begin
          chk("res_sum_idle", {28'd0, res_sum}, 0);
        end
      end
    join_none

    en = 1'b1;
    do_reset();

    // T1: single request, fixed latency
    step(1, 5, 6, 0, 0, 0, 1, 0, 11);
    idle(4);

    // T2: contention alternates starting with requester 0
    do_reset();
    step(1, 3, 4, 1, 9, 9, 1, 0, 7);
    step(1, 3, 4, 1, 9, 9, 0, 1, 2);
    step(1, 3, 4, 1, 9, 9, 1, 0, 7);
    step(1, 3, 4, 1, 9, 9, 0, 1, 2);
    chk("t2_cnt0", {30'd0, cnt0}, 2);
    chk("t2_cnt1", {30'd0, cnt1}, 2);

    // T3: carry out dropped
    step(0, 0, 0, 1, 15, 15, 0, 1, 14);
    chk("t3_cnt1", {30'd0, cnt1}, 3);
    idle(4);

    // T4: stop issue with two ops in flight, drain to idle
    step(1, 1, 2, 0, 0, 0, 1, 0, 3);
    step(0, 0, 0, 1, 4, 4, 0, 1, 8);
    en = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    chk("t4_busy_draining", {31'd0, busy}, 1);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy_idle", {31'd0, busy}, 0);

    // T5: reset one cycle after a grant suppresses the in-flight result
    en = 1'b1;
    @(posedge clk); #1;
    step(1, 7, 1, 0, 0, 0, 1, 0, 8);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_res_valid", {31'd0, res_valid}, 0);
    end
    @(posedge clk); #1;

    // T6: counter saturation at 2 bits
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0, 1, 0, 2);
    chk("t6_cnt0", {30'd0, cnt0}, 3);
    chk("t6_cnt1", {30'd0, cnt1}, 0);
    idle(5);

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
